// File: rtl/fir_axil_pkg.sv
// Shared constants for the FIR AXI4-Lite sample bridge: register map,
// CTRL/STATUS bit positions, AXI response codes and FSM state types.
package fir_axil_pkg;

  // Register word indices (byte offset >> 2): 0x0, 0x4, 0x8, 0xC
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIN    = 2'd1;
  localparam logic [1:0] REG_DOUT   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_IN_EMPTY  = 1;
  localparam int ST_OUT_FULL  = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_UDF       = 5;
  localparam int ST_IN_CNT    = 8;
  localparam int ST_OUT_CNT   = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

endpackage

// File: rtl/fir_axil_sample_bridge_if.sv
// AXI4-Lite bus bundle between a processor master and the sample bridge.
interface fir_axil_sample_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with combinational read port, occupancy count and a
// synchronous flush. A push while full is accepted if a pop happens in the
// same cycle; flush overrides both.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next pointers and occupancy; flush returns everything to empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/fir_axil_sample_bridge.sv
// AXI4-Lite front end for the FIR core: DIN writes feed an input FIFO that
// streams samples to the core, core results land in an output FIFO drained
// by DOUT reads. Exposes status, sticky ovf/udf flags and a level irq.
module fir_axil_sample_bridge
  import fir_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SAMPLE_W           = 16,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  fir_axil_sample_bridge_if.slave    s_axi,
  output logic [SAMPLE_W-1:0]        m_sample_tdata,
  output logic                       m_sample_tvalid,
  input  logic                       m_sample_tready,
  input  logic [SAMPLE_W-1:0]        s_result_tdata,
  input  logic                       s_result_tvalid,
  output logic                       s_result_tready,
  output logic                       irq
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [DW-1:0] sext(input logic signed [SAMPLE_W-1:0] v);
    return DW'(v);
  endfunction

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              awready_q, awready_d;
  logic              arready_q, arready_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [DW-1:0]     din_q, din_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              hold_q, hold_d;
  logic              irq_q, irq_d;

  logic              w_fire, r_fire;
  logic [1:0]        waddr, raddr;
  logic              flush, in_push, in_pop, out_push, out_pop;
  logic              in_full, in_empty, out_full, out_empty;
  logic [CNT_W-1:0]  in_count, out_count;
  logic [SAMPLE_W-1:0] out_dout;
  logic [DW-1:0]     status_word, ctrl_word;
  logic              unused_sigs;

  assign w_fire   = awready_q && s_axi.awvalid && s_axi.wvalid;
  assign r_fire   = arready_q && s_axi.arvalid;
  assign waddr    = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign raddr    = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Once valid has been shown it is held until taken, even if enable drops
  assign m_sample_tvalid = !in_empty && (enable_q || hold_q);
  assign in_pop          = m_sample_tvalid && m_sample_tready;
  assign s_result_tready = !out_full;
  assign out_push        = s_result_tvalid && s_result_tready;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign irq           = irq_q;

  assign unused_sigs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot,
                         s_axi.arprot, s_axi.wstrb[DW/8-1:1]};

  fir_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(ACLK), .rst_n(ARESETN), .flush(flush), .push(in_push), .pop(in_pop),
    .din(s_axi.wdata[SAMPLE_W-1:0]), .dout(m_sample_tdata),
    .full(in_full), .empty(in_empty), .count(in_count)
  );

  fir_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(ACLK), .rst_n(ARESETN), .flush(flush), .push(out_push), .pop(out_pop),
    .din(s_result_tdata), .dout(out_dout),
    .full(out_full), .empty(out_empty), .count(out_count)
  );

  // Read views of CTRL and STATUS; flush always reads back as 0
  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_ENABLE]   = enable_q;
    ctrl_word[CTRL_IRQ_EN]   = irq_en_q;
    status_word              = '0;
    status_word[ST_IN_FULL]   = in_full;
    status_word[ST_IN_EMPTY]  = in_empty;
    status_word[ST_OUT_FULL]  = out_full;
    status_word[ST_OUT_EMPTY] = out_empty;
    status_word[ST_OVF]       = ovf_q;
    status_word[ST_UDF]       = udf_q;
    status_word[ST_IN_CNT +: 4]  = 4'(in_count);
    status_word[ST_OUT_CNT +: 4] = 4'(out_count);
  end

  // Write/read FSMs and register side effects
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    din_d     = din_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    flush     = 1'b0;
    in_push   = 1'b0;
    out_pop   = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        awready_d = s_axi.awvalid && s_axi.wvalid && !awready_q;
        if (w_fire) begin
          w_state_d = W_RESP;
          bresp_d   = RESP_OKAY;
          case (waddr)
            REG_CTRL: begin
              if (s_axi.wstrb[0]) begin
                enable_d = s_axi.wdata[CTRL_ENABLE];
                irq_en_d = s_axi.wdata[CTRL_IRQ_EN];
                flush    = s_axi.wdata[CTRL_FLUSH];
              end
            end
            REG_DIN: begin
              din_d = s_axi.wdata;
              if (enable_q) begin
                // A same-cycle stream pop frees the slot this push needs
                if (in_full && !in_pop) begin
                  ovf_d   = 1'b1;
                  bresp_d = RESP_SLVERR;
                end else begin
                  in_push = 1'b1;
                end
              end
            end
            REG_STATUS: begin
              if (s_axi.wstrb[0]) begin
                if (s_axi.wdata[ST_OVF]) ovf_d = 1'b0;
                if (s_axi.wdata[ST_UDF]) udf_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    case (r_state_q)
      R_IDLE: begin
        arready_d = s_axi.arvalid && !arready_q;
        if (r_fire) begin
          r_state_d = R_DATA;
          rresp_d   = RESP_OKAY;
          case (raddr)
            REG_CTRL: rdata_d = ctrl_word;
            REG_DIN:  rdata_d = din_q;
            REG_DOUT: begin
              if (out_empty) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
                udf_d   = 1'b1;  // a new underflow wins over a same-cycle W1C
              end else begin
                rdata_d = sext(out_dout);
                out_pop = 1'b1;
              end
            end
            default:  rdata_d = status_word;
          endcase
        end
      end
      R_DATA: begin
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    hold_d = flush ? 1'b0 : (m_sample_tvalid && !m_sample_tready);
    irq_d  = irq_en_q && !out_empty;
  end

  // All bridge state, cleared by the asynchronous reset
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      din_q     <= '0;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      hold_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      din_q     <= din_d;
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      hold_q    <= hold_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_fir_axil_sample_bridge.sv
// Directed + randomized bench for fir_axil_sample_bridge with a queue-based
// reference model of the register map and both FIFOs.
module tb_fir_axil_sample_bridge;
  import fir_axil_pkg::*;

  localparam int SW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [SW-1:0] m_sample_tdata;
  logic          m_sample_tvalid;
  logic          m_sample_tready;
  logic [SW-1:0] s_result_tdata;
  logic          s_result_tvalid;
  logic          s_result_tready;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_en, m_irqen, m_ovf, m_udf;
  logic [31:0]   m_din;
  logic [SW-1:0] in_q[$];
  logic [SW-1:0] out_q[$];

  fir_axil_sample_bridge_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  fir_axil_sample_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
    .SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK(clk), .ARESETN(rstn), .s_axi(axi),
    .m_sample_tdata(m_sample_tdata), .m_sample_tvalid(m_sample_tvalid),
    .m_sample_tready(m_sample_tready),
    .s_result_tdata(s_result_tdata), .s_result_tvalid(s_result_tvalid),
    .s_result_tready(s_result_tready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_udf = 0; m_din = '0;
    in_q.delete(); out_q.delete();
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    s[0]     = (in_q.size() == DEPTH);
    s[1]     = (in_q.size() == 0);
    s[2]     = (out_q.size() == DEPTH);
    s[3]     = (out_q.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_udf;
    s[11:8]  = 4'(in_q.size());
    s[19:16] = 4'(out_q.size());
    return s;
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] d,
                             input logic [3:0] strb, output logic [1:0] resp);
    resp = RESP_OKAY;
    case (addr[3:2])
      2'd0: if (strb[0]) begin
        m_en = d[0]; m_irqen = d[2];
        if (d[1]) begin in_q.delete(); out_q.delete(); end
      end
      2'd1: begin
        m_din = d;
        if (m_en) begin
          if (in_q.size() >= DEPTH) begin m_ovf = 1; resp = RESP_SLVERR; end
          else in_q.push_back(d[SW-1:0]);
        end
      end
      2'd3: if (strb[0]) begin
        if (d[4]) m_ovf = 0;
        if (d[5]) m_udf = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [3:0] addr, output logic [31:0] d, output logic [1:0] resp);
    resp = RESP_OKAY;
    d    = '0;
    case (addr[3:2])
      2'd0: d = {29'd0, m_irqen, 1'b0, m_en};
      2'd1: d = m_din;
      2'd2: begin
        if (out_q.size() == 0) begin resp = RESP_SLVERR; m_udf = 1; end
        else begin
          logic [SW-1:0] v;
          v = out_q.pop_front();
          d = {{(32-SW){v[SW-1]}}, v};
        end
      end
      default: d = model_status();
    endcase
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d,
                           input logic [3:0] strb, input bit coinc_pop, input string tag);
    logic [1:0] exp_resp;
    bit seen;
    @(negedge clk);
    axi.awaddr = addr; axi.wdata = d; axi.wstrb = strb;
    axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (axi.awready) seen = 1;
    end
    if (!seen) begin
      check({tag, "_awready_timeout"}, 32'(seen), 32'd1);
      axi.awvalid = 0; axi.wvalid = 0;
      return;
    end
    check({tag, "_wready"}, 32'(axi.wready), 32'd1);
    if (coinc_pop) begin
      check({tag, "_pop_tvalid"}, 32'(m_sample_tvalid), 32'd1);
      check({tag, "_pop_tdata"}, 32'(m_sample_tdata), 32'(in_q[0]));
      m_sample_tready = 1;
      void'(in_q.pop_front());
    end
    model_write(addr, d, strb, exp_resp);
    @(negedge clk);
    axi.awvalid = 0; axi.wvalid = 0; m_sample_tready = 0;
    check({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(axi.bresp), 32'(exp_resp));
    @(negedge clk);
    axi.bready = 0;
    check({tag, "_bvalid_clr"}, 32'(axi.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit seen;
    @(negedge clk);
    axi.araddr = addr; axi.arvalid = 1; axi.rready = 1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (axi.arready) seen = 1;
    end
    if (!seen) begin
      check({tag, "_arready_timeout"}, 32'(seen), 32'd1);
      axi.arvalid = 0;
      return;
    end
    model_read(addr, exp_d, exp_r);
    @(negedge clk);
    axi.arvalid = 0;
    check({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    check({tag, "_rdata"}, axi.rdata, exp_d);
    check({tag, "_rresp"}, 32'(axi.rresp), 32'(exp_r));
    @(negedge clk);
    axi.rready = 0;
    check({tag, "_rvalid_clr"}, 32'(axi.rvalid), 32'd0);
  endtask

  task automatic take_sample(input string tag);
    bit exp_v;
    @(negedge clk);
    exp_v = m_en && (in_q.size() != 0);
    check({tag, "_tvalid"}, 32'(m_sample_tvalid), 32'(exp_v));
    if (exp_v) begin
      check({tag, "_tdata"}, 32'(m_sample_tdata), 32'(in_q[0]));
      m_sample_tready = 1;
      @(negedge clk);
      m_sample_tready = 0;
      void'(in_q.pop_front());
    end
  endtask

  task automatic push_result(input logic [SW-1:0] d, input string tag);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = (out_q.size() < DEPTH);
    check({tag, "_tready"}, 32'(s_result_tready), 32'(exp_rdy));
    if (exp_rdy) begin
      s_result_tdata = d; s_result_tvalid = 1;
      @(negedge clk);
      s_result_tvalid = 0;
      out_q.push_back(d);
    end
  endtask

  task automatic check_irq(input string tag);
    repeat (2) @(negedge clk);
    check(tag, 32'(irq), 32'(m_irqen && (out_q.size() != 0)));
  endtask

  initial begin
    logic [31:0] r1, r2;
    rstn = 0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0;
    axi.wstrb = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;
    m_sample_tready = 0; s_result_tdata = '0; s_result_tvalid = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1;

    // Reset state
    @(negedge clk);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_bresp", 32'(axi.bresp), 32'd0);
    check("rst_rresp", 32'(axi.rresp), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    check("rst_tvalid", 32'(m_sample_tvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_result_tready", 32'(s_result_tready), 32'd1);
    axi_read(4'h0, "rst_ctrl");
    axi_read(4'h4, "rst_din");
    axi_read(4'hC, "rst_status");

    // Write 1..4 to each register and read back
    axi_write(4'h0, 32'd1, 4'hF, 0, "w_ctrl");
    axi_write(4'h4, 32'd2, 4'hF, 0, "w_din");
    axi_write(4'h8, 32'd3, 4'hF, 0, "w_dout");
    axi_write(4'hC, 32'd4, 4'hF, 0, "w_status");
    axi_read(4'h0, "r_ctrl");
    axi_read(4'h4, "r_din");
    axi_read(4'hC, "r_status");
    axi_read(4'h8, "r_dout_empty");
    axi_read(4'hC, "r_status_udf");
    take_sample("drain_first");

    // Fill the input FIFO and overflow it
    axi_write(4'hC, 32'h20, 4'hF, 0, "w1c_udf");
    for (int i = 0; i < 5; i++) axi_write(4'h4, 32'h11 + i, 4'hF, 0, "din_fill");
    axi_read(4'hC, "r_status_full");
    check("full_tdata", 32'(m_sample_tdata), 32'h0011);

    // Push into full FIFO coinciding with a stream pop
    r1 = $urandom;
    axi_write(4'h4, r1, 4'hF, 1, "din_coinc");
    axi_read(4'hC, "r_status_coinc");
    for (int i = 0; i < 4; i++) take_sample("drain_order");

    // Results, sign extension and irq
    axi_write(4'h0, 32'h5, 4'hF, 0, "w_ctrl_irq");
    push_result(16'hFFFE, "res_a");
    push_result(16'h0003, "res_b");
    check_irq("irq_high");
    axi_read(4'h8, "r_dout_a");
    axi_read(4'h8, "r_dout_b");
    check_irq("irq_low");
    axi_write(4'h0, 32'h0, 4'h0, 0, "w_ctrl_nostrb");
    axi_read(4'h0, "r_ctrl_nostrb");

    // Hold of tvalid across enable clear, then flush
    r1 = $urandom; r2 = $urandom;
    axi_write(4'h4, r1, 4'hF, 0, "q_a");
    axi_write(4'h4, r2, 4'hF, 0, "q_b");
    axi_write(4'h0, 32'h4, 4'hF, 0, "w_ctrl_dis");
    check("hold_tvalid", 32'(m_sample_tvalid), 32'd1);
    check("hold_tdata", 32'(m_sample_tdata), 32'(in_q[0]));
    axi_write(4'h0, 32'h6, 4'hF, 0, "w_flush");
    check("flush_tvalid", 32'(m_sample_tvalid), 32'd0);
    axi_read(4'hC, "r_status_flush");
    axi_read(4'h0, "r_ctrl_flush");
    axi_write(4'h0, 32'h5, 4'hF, 0, "w_ctrl_en");

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: axi_write(4'h4, $urandom, 4'hF, 0, "rnd_din");
        1: take_sample("rnd_take");
        2: push_result(16'($urandom), "rnd_res");
        3: axi_read(4'h8, "rnd_dout");
        default: axi_read(4'hC, "rnd_status");
      endcase
    end
    check_irq("rnd_irq");

    // Reset while BVALID is pending
    @(negedge clk);
    axi.awaddr = 4'h4; axi.wdata = $urandom; axi.wstrb = 4'hF;
    axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
    begin
      bit seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (axi.awready) seen = 1;
      end
      check("mid_awready", 32'(seen), 32'd1);
    end
    @(negedge clk);
    axi.awvalid = 0; axi.wvalid = 0;
    check("mid_bvalid", 32'(axi.bvalid), 32'd1);
    #2 rstn = 0;
    #1;
    check("mid_rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("mid_rst_tvalid", 32'(m_sample_tvalid), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
    axi.bready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_bvalid", 32'(axi.bvalid), 32'd0);
    end
    axi.bready = 0;
    axi_read(4'h0, "post_ctrl");
    axi_read(4'h4, "post_din");
    axi_read(4'hC, "post_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_axil_sample_bridge.md
# fir_axil_sample_bridge

AXI4-Lite slave front end that sits directly upstream and downstream of the FIR filter core inside the FIR_Filter_V5 IP. The processor writes input samples through a memory-mapped register into a small input FIFO, and the FIFO feeds the core over a valid/ready stream. Filter results return over a second stream into an output FIFO that the processor drains by register reads. Status, sticky error flags and a level interrupt are also exposed.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; 4 word registers.
- SAMPLE_W, 16: sample and result width; signed two's complement.
- FIFO_DEPTH, 4: entries per FIFO; power of two, 2..8.
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels; AWPROT is ignored.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels; ARPROT is ignored.
- m_sample_tdata  out  SAMPLE_W  sample to the FIR core.
- m_sample_tvalid  out  1 / m_sample_tready  in  1  sample handshake.
- s_result_tdata  in  SAMPLE_W  result from the FIR core.
- s_result_tvalid  in  1 / s_result_tready  out  1  result handshake.
- irq  out  1  registered level interrupt.

## Operation
- Register map (word address):
  - 0x0 CTRL (R/W, honours WSTRB): bit0 enable, bit1 flush (self-clearing, reads 0), bit2 irq_en.
  - 0x4 DIN: a write with enable=1 pushes WDATA[SAMPLE_W-1:0] into the input FIFO. A write with enable=0 is ignored but still returns OKAY. Reading returns the last value written (32 bits, stored regardless of enable).
  - 0x8 DOUT: a read pops the output FIFO and returns the result sign-extended to 32 bits.
  - 0xC STATUS: bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty, bit4 ovf, bit5 udf, [11:8] in_count, [19:16] out_count. Bits 4/5 are write-1-to-clear; all other bits are read-only.
- Error handling:
  - Push to a full input FIFO: data is dropped, ovf is set, BRESP=SLVERR (2'b10).
  - Exception: a push to a full FIFO in the same cycle as an m_sample pop is accepted.
  - Read of DOUT while out_empty: RDATA=0, RRESP=SLVERR, udf is set.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, when AWVALID and WVALID are both high, AWREADY and WREADY pulse together for 1 cycle, the register side effect executes, and the FSM moves to W_RESP.
  - W_RESP holds BVALID until BREADY, then returns to W_IDLE.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, ARREADY pulses for 1 cycle on ARVALID. RDATA is captured (and a DOUT pop performed) in the same cycle, and the FSM moves to R_DATA.
  - R_DATA holds RVALID until RREADY.
- m_sample_tvalid = enable && !in_empty. Once asserted, it stays high with stable tdata until the handshake, even if enable clears.
- s_result_tready = !out_full; results are never dropped inside the block.
- irq = irq_en && !out_empty, registered.
- Flush: both FIFOs and their counts go to 0; sticky flags are unchanged. Flush beats a same-cycle push or stream handshake, and any in-flight m_sample_tvalid drops.
- Unmapped addresses cannot occur (4-bit address); ADDR[1:0] is ignored.

## Timing
- Reset: all AXI READY/VALID outputs are 0, BRESP/RRESP/RDATA are 0, CTRL=0, DIN=0, both FIFOs are empty (status bits 1 and 3 = 1), ovf/udf are 0, m_sample_tvalid=0, irq=0. s_result_tready is 1 in the first cycle after reset release.
- Write latency: AW/W handshake at cycle N, BVALID at N+1. The pushed sample is visible on m_sample_tvalid at N+1 (given enable).
- Read latency: AR handshake at N, RVALID at N+1.
- Result handshake at N: out_count and STATUS update at N+1, and irq rises at N+2.
- Reset asserted mid-transaction aborts everything immediately; no BVALID or RVALID is issued afterward.

## Structure
- Package fir_axil_pkg holds:
  - register offsets;
  - CTRL/STATUS bit positions;
  - RESP_OKAY/RESP_SLVERR;
  - the write and read FSM state enums.
- Sub-module fir_sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, with pointer wrap-around. It is instantiated twice.

## Test plan
- Reset, then write 1,2,3,4 to 0x0..0xC and read them back. Expected: CTRL reads 0x1 (flush bit is self-clearing, irq_en gets bit2 of 0x1=0); DIN reads 0x2; DOUT reads 0 with SLVERR and sets udf; STATUS reads with ovf=0 and udf=0 (W1C of value 4 leaves ovf=0, and the udf read happens after it).
- enable=1, m_sample_tready=0, write 0x11..0x15 to DIN. Expected: 4 OKAY then 1 SLVERR; STATUS shows in_full=1, in_count=4, ovf=1; m_sample_tdata=0x0011.
- Input FIFO full, DIN write coinciding with an m_sample handshake. Expected: OKAY, in_count stays 4, order preserved.
- Drive results 0xFFFE and 0x0003 with irq_en=1. Expected: irq=1; DOUT reads 0xFFFFFFFE then 0x00000003; irq=0 after the second pop.
- 2 samples queued, write CTRL flush=1. Expected: in_empty=1, m_sample_tvalid=0 next cycle, ovf retained.
- ARESETN low while BVALID is pending. Expected: BVALID=0 immediately, all reset values restored, no response after release.
